// File: rtl/tdm_pkg.sv
// tdm_pkg: transmitter state encoding and counter width helper shared by the tdm_link files
package tdm_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/tdm_timebase.sv
// tdm_timebase: prescaler (0..DIV-1) and slot counter (0..WIDTH-1), held at zero while run=0; ports clk, rst_n, run -> pre, slot, bit_end, frame_end
module tdm_timebase
  import tdm_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       run,
  output logic [idx_w(DIV)-1:0]      pre,
  output logic [idx_w(WIDTH)-1:0]    slot,
  output logic                       bit_end,
  output logic                       frame_end
);
  localparam int PW = idx_w(DIV);
  localparam int IW = idx_w(WIDTH);
  assign bit_end   = run && pre == PW'(DIV - 1);
  assign frame_end = bit_end && slot == IW'(WIDTH - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre  <= '0;
      slot <= '0;
    end else if (!run) begin
      pre  <= '0;
      slot <= '0;
    end else begin
      pre <= bit_end ? '0 : pre + 1'b1;
      if (bit_end) slot <= frame_end ? '0 : slot + 1'b1;
    end
  end
endmodule

// File: rtl/tdm_link.sv
// tdm_link: TDM serial transmitter plus receiver sharing one timebase; ports din/load/auto_mode -> ready/sdata/frame/bit_idx, sdata_in/frame_in -> dout/dout_valid
module tdm_link
  import tdm_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DIV       = 4,
  parameter int LSB_FIRST = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         din,
  input  logic                     load,
  input  logic                     auto_mode,
  output logic                     ready,
  output logic                     sdata,
  output logic                     frame,
  output logic [idx_w(WIDTH)-1:0]  bit_idx,
  input  logic                     sdata_in,
  input  logic                     frame_in,
  output logic [WIDTH-1:0]         dout,
  output logic                     dout_valid
);
  localparam int IW = idx_w(WIDTH);
  localparam int PW = idx_w(DIV);
  state_t state, state_n;
  logic [WIDTH-1:0] word, rx_word, rx_next;
  logic [PW-1:0] pre;
  logic [IW-1:0] slot, rx_slot, rx_cur;
  logic run, start, first, bit_end, frame_end;
  function automatic logic [IW-1:0] pos(input logic [IW-1:0] k);
    return (LSB_FIRST != 0) ? k : IW'(WIDTH - 1) - k;
  endfunction
  assign run = state == SHIFT;
  tdm_timebase #(.WIDTH(WIDTH), .DIV(DIV)) u_timebase (
    .clk(clk), .rst_n(rst_n), .run(run), .pre(pre), .slot(slot),
    .bit_end(bit_end), .frame_end(frame_end)
  );
  always_comb begin
    ready   = !run || frame_end;
    start   = ready && (load || auto_mode);
    state_n = start ? SHIFT : (frame_end ? IDLE : state);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      word  <= '0;
    end else begin
      state <= state_n;
      if (start) word <= din;
    end
  end
  assign sdata   = run && word[pos(slot)];
  assign frame   = run && slot == '0;
  assign bit_idx = slot;
  assign first   = run && pre == '0;
  assign rx_cur  = (first && frame_in) ? '0 : rx_slot;
  always_comb begin
    rx_next             = rx_word;
    rx_next[pos(rx_cur)] = sdata_in;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_word    <= '0;
      rx_slot    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (bit_end) begin
        rx_word <= rx_next;
        rx_slot <= (rx_cur == IW'(WIDTH - 1)) ? '0 : rx_cur + 1'b1;
        if (rx_cur == IW'(WIDTH - 1)) begin
          dout       <= rx_next;
          dout_valid <= 1'b1;
        end
      end else if (first && frame_in) rx_slot <= '0;
    end
  end
endmodule

// File: tb/tb_tdm_link.sv
// tb_tdm_link: randomized scoreboard bench for tdm_link in three loopback configurations
module tb_tdm_link;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0, tests = 0, fails = 0, ndone = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {int due; int w;} exp_t;
  task automatic chk(input int g, input string n, input int a, input int e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL cfg%0d %s at cycle %0d: got %0h, want %0h", g, n, cyc, a, e);
    end
  endtask
  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int W = (g == 2) ? 2 : 8;
    localparam int D = (g == 2) ? 1 : 4;
    localparam int L = (g == 1) ? 0 : 1;
    localparam int RS = (W > 3) ? 3 : 1;
    localparam logic [31:0] FIRST = (g == 1) ? 32'h80 : 32'hA5;
    logic rst_n, load, auto_mode, ready, sdata, frame, dout_valid;
    logic [W-1:0] din, dout;
    logic [tdm_pkg::idx_w(W)-1:0] bit_idx;
    int lt = -100000, lw = 0;
    exp_t q[$];
    tdm_link #(.WIDTH(W), .DIV(D), .LSB_FIRST(L)) dut (
      .clk(clk), .rst_n(rst_n), .din(din), .load(load), .auto_mode(auto_mode),
      .ready(ready), .sdata(sdata), .frame(frame), .bit_idx(bit_idx),
      .sdata_in(sdata), .frame_in(frame), .dout(dout), .dout_valid(dout_valid)
    );
    always @(negedge clk) begin : model
      int k;
      logic a, er;
      if (!rst_n) begin
        lt = -100000;
        q.delete();
      end
      a  = cyc > lt && cyc <= lt + W * D;
      k  = a ? (cyc - lt - 1) / D : 0;
      er = !a || cyc == lt + W * D;
      chk(g, "line{ready,sdata,frame,idx}",
          int'(ready) * 1024 + int'(sdata) * 512 + int'(frame) * 256 + int'(bit_idx),
          int'(er) * 1024 + (a ? ((lw >> (L != 0 ? k : W - 1 - k)) & 1) : 0) * 512
          + int'(a && k == 0) * 256 + k);
      if (rst_n && er && (load || auto_mode)) begin
        lt = cyc;
        lw = int'(din);
        q.push_back('{cyc + W * D + 1, int'(din)});
      end
    end
    always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n && q.size() > 0 && q[0].due < cyc) begin
        chk(g, "dout_valid_missing", 0, 1);
        void'(q.pop_front());
      end
      if (dout_valid) begin
        if (q.size() == 0) chk(g, "dout_valid_spurious", 1, 0);
        else begin
          e = q.pop_front();
          chk(g, "dout", int'(dout), e.w);
          chk(g, "dout_valid_cycle", cyc, e.due);
        end
      end
    end
    initial begin
      rst_n = 1'b0; load = 1'b0; auto_mode = 1'b0; din = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1; load = 1'b1; din = W'(FIRST);
      @(posedge clk); #1 load = 1'b0;
      repeat (W * D - 2) begin
        load = 1'($urandom_range(1)); din = W'($urandom);
        @(posedge clk); #1;
      end
      load = 1'b0;
      repeat (W * D + 4) @(posedge clk);
      #1 auto_mode = 1'b1; din = W'(1);
      @(posedge clk); #1 din = W'(2);
      repeat (W * D) @(posedge clk);
      #1 din = W'(3);
      repeat (W * D) @(posedge clk);
      #1 auto_mode = 1'b0;
      repeat (W * D + 4) @(posedge clk);
      #1 load = 1'b1; din = W'(32'h5A);
      @(posedge clk); #1 load = 1'b0; din = W'($urandom);
      repeat (RS * D) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk(g, "rst_sdata", int'(sdata), 0);
      chk(g, "rst_ready", int'(ready), 1);
      chk(g, "rst_frame", int'(frame), 0);
      chk(g, "rst_bit_idx", int'(bit_idx), 0);
      chk(g, "rst_dout", int'(dout), 0);
      chk(g, "rst_dout_valid", int'(dout_valid), 0);
      @(posedge clk); #1 rst_n = 1'b1; load = 1'b1; din = W'(32'hC3);
      @(posedge clk); #1 load = 1'b0;
      repeat (W * D + 4) @(posedge clk);
      #1;
      repeat (300) begin
        load = (W == 2) ? 1'b1 : ($urandom_range(3) == 0);
        auto_mode = (W != 2) && ($urandom_range(15) == 0);
        din = W'($urandom);
        @(posedge clk); #1;
      end
      load = 1'b0; auto_mode = 1'b0;
      repeat (W * D + 4) @(posedge clk);
      @(negedge clk);
      chk(g, "scoreboard_drained", q.size(), 0);
      ndone++;
    end
  end
  initial begin
    fork
      wait (ndone == 3);
      begin
        #500000;
        tests++;
        fails++;
        $display("FAIL timeout: %0d of 3 configurations finished", ndone);
      end
    join_any
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tdm_link.md
TDM_LINK -- requirements
Module: tdm_link

Interface
REQ-001 Parameter WIDTH, default 8, is the frame word width in bits, legal range 2..32.
REQ-002 Parameter DIV, default 4, is the number of clk cycles each bit is held on the line, legal range 1..256.
REQ-003 Parameter LSB_FIRST, default 1: 1 transmits bit 0 first; 0 transmits bit WIDTH-1 first.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port din, input, WIDTH bits: parallel word to transmit.
REQ-007 Port load, input, 1 bit: request to transmit din.
REQ-008 Port auto_mode, input, 1 bit: when 1, din is re-captured at every frame boundary with no idle gap.
REQ-009 Port ready, output, 1 bit: a load is accepted this cycle.
REQ-010 Port sdata, output, 1 bit: serial line.
REQ-011 Port frame, output, 1 bit: high during the DIV cycles of the first bit of each frame.
REQ-012 Port bit_idx, output, clog2(WIDTH) bits: transmission slot (0..WIDTH-1) of the bit currently on sdata.
REQ-013 Port sdata_in, input, 1 bit: receiver serial input (tied to sdata for loopback).
REQ-014 Port frame_in, input, 1 bit: receiver frame marker (tied to frame for loopback).
REQ-015 Port dout, output, WIDTH bits: last complete received word.
REQ-016 Port dout_valid, output, 1 bit: one-cycle pulse when dout updates.

Function
REQ-017 Transmitter FSM states are IDLE and SHIFT; the reset state is IDLE.
REQ-018 Start condition: (load=1 or auto_mode=1) while ready=1.
REQ-019 ready=1 in IDLE, and in SHIFT only on the final cycle of the final bit; otherwise ready=0.
REQ-020 On a start in cycle t: din is captured at the edge ending t; bit slot 0 appears on sdata during cycles t+1..t+DIV; slot k appears during t+1+k*DIV..t+(k+1)*DIV.
REQ-021 On the final cycle of a frame, a start yields an immediately following frame with no gap; otherwise the FSM enters IDLE.
REQ-022 In IDLE: sdata=0, frame=0, bit_idx=0.
REQ-023 din changes after capture do not affect the frame in flight.
REQ-024 The prescaler counts 0..DIV-1 and wraps; bit_idx increments on the wrap and wraps from WIDTH-1 to 0 at a frame boundary.
REQ-025 The receiver samples sdata_in on the last cycle (prescaler=DIV-1) of each bit period, using the transmitter's timing.
REQ-026 The receiver writes each sampled bit to the dout position given by LSB_FIRST and its slot.
REQ-027 The receiver's slot counter resets to 0 whenever frame_in=1 on a bit's first cycle.
REQ-028 For a frame started in cycle t, dout holds the word and dout_valid=1 in cycle t+WIDTH*DIV+1 only.
REQ-029 A frame_in rising edge mid-word discards the partial word; no dout_valid is produced for it.
REQ-030 load=1 while ready=0 is ignored, with no queuing.

Reset
REQ-031 While rst_n=0, all state clears asynchronously: FSM=IDLE, counters=0, ready=1, sdata=0, frame=0, bit_idx=0, dout=0, dout_valid=0.
REQ-032 Reset asserted mid-frame aborts the frame; no dout_valid follows.
REQ-033 The first start is accepted on the first rising edge after rst_n deasserts.

Structure
REQ-034 The FSM state encoding and the bit_idx width function belong in the shared package tdm_pkg.
REQ-035 The prescaler plus slot counter is one sub-module, tdm_timebase, shared by the transmit and receive halves.

Verification
REQ-036 Loopback test: WIDTH=8, DIV=4, LSB_FIRST=1; load 8'hA5 for one cycle -> sdata bits 1,0,1,0,0,1,0,1, each held 4 cycles; dout=8'hA5 with a single dout_valid pulse 33 cycles after the load cycle.
REQ-037 MSB-first test: LSB_FIRST=0, din=8'h80 -> sdata=1 only in slot 0, and dout=8'h80.
REQ-038 Auto-mode test: auto_mode=1 with din changed each frame (8'h01, 8'h02, 8'h03) -> gapless frames, frame pulses every 32 cycles, and dout_valid pulses with 8'h01, 8'h02, 8'h03.
REQ-039 Busy-load test: load pulses mid-frame -> ignored, ready=0, and the frame in flight is unchanged.
REQ-040 Reset test: rst_n low at slot 3 -> outputs take reset values immediately, no dout_valid, and a new load afterwards transmits correctly.
REQ-041 Corner test: WIDTH=2, DIV=1 with load held high -> continuous frames and dout_valid every 2 cycles.
